// File: rtl/sub_bytes_seq_if.sv
// Block-level handshake bundle for the SubBytes stage: input block, output block, status.
interface sub_bytes_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;
  logic         busy;

  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out, busy
  );

  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out, busy
  );
endinterface

// File: rtl/sub_bytes_seq.sv
// Multi-cycle AES SubBytes: LANES forward S-boxes walk a 128-bit state in 16/LANES cycles,
// then hold the result on a valid/ready port until the downstream stage takes it.

module sub_bytes_lane (
  input  logic [7:0] a,
  output logic [7:0] s
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] sq;
  logic [7:0] inv;

  // a^254 is the field inverse (and maps 0 to 0): product of a^2, a^4, ..., a^128
  always_comb begin
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
        {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module sub_bytes_seq #(
  parameter int LANES = 4
) (
  input logic           clk,
  input logic           rst,
  sub_bytes_seq_if.slave bus
);
  localparam int CYCLES = 16 / LANES;
  localparam int CNT_W  = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SUB, HOLD} state_t;

  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  // Group view of the state: group CYCLES-1 holds bytes 0..LANES-1 (the top of the word)
  logic [CYCLES-1:0][LANES-1:0][7:0] work, work_nxt;
  logic [CNT_W-1:0]      gidx;
  logic [LANES-1:0][7:0] lane_in, lane_out;
  logic                  out_valid_q, busy_q;
  logic                  accept;

  assign gidx    = CNT_W'(CYCLES - 1) - cnt;
  assign lane_in = work[gidx];

  sub_bytes_lane u_lane [LANES-1:0] (.a(lane_in), .s(lane_out));

  assign bus.in_ready  = (state == IDLE) & ~rst;
  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = work;
  assign bus.busy      = busy_q;
  assign accept        = bus.in_valid & bus.in_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    work_nxt  = work;
    case (state)
      IDLE: if (accept) begin
        work_nxt  = bus.data_in;
        cnt_nxt   = '0;
        state_nxt = SUB;
      end
      SUB: begin
        work_nxt[gidx] = lane_out;
        if (cnt == CNT_W'(CYCLES - 1)) begin
          cnt_nxt   = '0;
          state_nxt = HOLD;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HOLD: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      work        <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      work        <= work_nxt;
      out_valid_q <= (state_nxt == HOLD);
      busy_q      <= (state_nxt != IDLE);
    end
  end
endmodule

// File: tb/tb_sub_bytes_seq.sv
// Bench for sub_bytes_seq at LANES=4,1,16: vector table plus hold/reset/back-to-back sequences,
// scoreboarded against an independent brute-force S-box model.
module tb_sub_bytes_seq;
  localparam int NL = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NL-1:0] iv, ordy, irdy, ov, bsy;
  logic [127:0]  din [NL];
  logic [127:0]  dout [NL];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NL; g++) begin : g_dut
    localparam int L = (g == 0) ? 4 : (g == 1) ? 1 : 16;
    sub_bytes_seq_if bus ();
    assign bus.in_valid  = iv[g];
    assign bus.data_in   = din[g];
    assign bus.out_ready = ordy[g];
    assign irdy[g]       = bus.in_ready;
    assign ov[g]         = bus.out_valid;
    assign dout[g]       = bus.data_out;
    assign bsy[g]        = bus.busy;
    sub_bytes_seq #(.LANES(L)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  end

  function automatic int lanes_of(int d);
    return (d == 0) ? 4 : (d == 1) ? 1 : 16;
  endfunction

  // reference: carry-less product then reduction, inverse by exhaustive search, FIPS affine
  function automatic logic [7:0] ref_mul(logic [7:0] a, logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] ref_sbox(logic [7:0] x);
    logic [7:0] inv, c, b;
    inv = 8'h00;
    c   = 8'h63;
    if (x != 8'h00)
      for (int y = 1; y < 256; y++) if (ref_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
    for (int i = 0; i < 8; i++)
      b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
    return b;
  endfunction

  logic [7:0] sbox_tbl [256];

  function automatic logic [127:0] model_blk(logic [127:0] x);
    logic [127:0] y;
    for (int k = 0; k < 16; k++) y[127-8*k -: 8] = sbox_tbl[x[127-8*k -: 8]];
    return y;
  endfunction

  int total = 0;
  int bad   = 0;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  logic [127:0] sb [$];
  int           acc_q [$];
  int           ret_q [$];
  logic [127:0] got [$];
  logic [127:0] stim [$];
  int           n_acc = 0;
  logic         prev_ov = 1'b0;

  // one cycle: sample at negedge, drive after the next posedge
  task automatic tick(int d);
    @(negedge clk);
    if (!rst) begin
      if (iv[d] && irdy[d]) begin
        sb.push_back(model_blk(din[d]));
        acc_q.push_back(cyc + 1);
        n_acc++;
      end
      if (ov[d] && !prev_ov) begin
        if (acc_q.size() == 0) chk($sformatf("spurious_valid_l%0d", lanes_of(d)), 128'(ov[d]), 128'd0);
        else chk($sformatf("latency_l%0d", lanes_of(d)), 128'(cyc - acc_q[0]), 128'(16 / lanes_of(d)));
      end
      if (ov[d] && ordy[d]) begin
        if (sb.size() == 0) chk($sformatf("extra_out_l%0d", lanes_of(d)), 128'(ov[d]), 128'd0);
        else begin
          chk($sformatf("sb_data_l%0d", lanes_of(d)), dout[d], sb.pop_front());
          void'(acc_q.pop_front());
          got.push_back(dout[d]);
          ret_q.push_back(cyc);
        end
      end
    end
    prev_ov = ov[d];
    @(posedge clk);
    #1;
  endtask

  // feed all of stim with in_valid held high, out_ready tied high
  task automatic run_stream(int d, int budget);
    int idx, n, g0, t, a0;
    idx = 0; n = stim.size(); g0 = got.size(); t = 0;
    ordy[d] = 1'b1; iv[d] = 1'b1; din[d] = stim[0];
    prev_ov = ov[d];
    while ((got.size() - g0) < n && t < budget) begin
      a0 = n_acc;
      tick(d);
      t++;
      if (n_acc != a0) begin
        idx++;
        if (idx < n) din[d] = stim[idx];
        else iv[d] = 1'b0;
      end
    end
    iv[d] = 1'b0;
    chk($sformatf("stream_count_l%0d", lanes_of(d)), 128'(got.size() - g0), 128'(n));
  endtask

  typedef struct {
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;
  vec_t tbl [17];

  initial begin
    logic [127:0] o, b1, b2;
    int t, L;
    for (int x = 0; x < 256; x++) sbox_tbl[x] = ref_sbox(8'(x));

    tbl[0].din = 128'h00112233445566778899aabbccddeeff;
    tbl[0].exp = 128'h638293c31bfc33f5c4eeacea4bc12816;
    for (int b = 0; b < 16; b++) begin
      for (int k = 0; k < 16; k++) tbl[b+1].din[127-8*k -: 8] = 8'(b*16 + k);
      tbl[b+1].exp = model_blk(tbl[b+1].din);
    end

    rst = 1'b1; iv = '0; ordy = '0;
    for (int d = 0; d < NL; d++) din[d] = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < NL; d++) begin
      chk($sformatf("rst_valid_%0d", d), 128'(ov[d]), 128'd0);
      chk($sformatf("rst_data_%0d", d), dout[d], 128'd0);
      chk($sformatf("rst_busy_%0d", d), 128'(bsy[d]), 128'd0);
      chk($sformatf("rst_ready_in_rst_%0d", d), 128'(irdy[d]), 128'd0);
    end
    rst = 1'b0;
    #1;
    for (int d = 0; d < NL; d++) chk($sformatf("ready_after_rst_%0d", d), 128'(irdy[d]), 128'd1);

    // table vectors and back-to-back stream on every lane width
    for (int d = 0; d < NL; d++) begin
      L = lanes_of(d);
      for (int i = 0; i < 17; i++) begin
        stim = {tbl[i].din};
        run_stream(d, 60);
        o = got[got.size()-1];
        chk($sformatf("vec%0d_l%0d", i, L), o, tbl[i].exp);
        if (i == 1) chk($sformatf("s00_l%0d", L), 128'(o[127:120]), 128'h63);
        if (i == 6) chk($sformatf("s53_l%0d", L), 128'(o[103:96]), 128'hed);
        if (i == 16) chk($sformatf("sff_l%0d", L), 128'(o[7:0]), 128'h16);
      end
      stim = {tbl[0].din, tbl[3].din, tbl[9].din};
      run_stream(d, 200);
      chk($sformatf("b2b_gap1_l%0d", L), 128'(ret_q[ret_q.size()-2] - ret_q[ret_q.size()-3]), 128'(16/L + 2));
      chk($sformatf("b2b_gap2_l%0d", L), 128'(ret_q[ret_q.size()-1] - ret_q[ret_q.size()-2]), 128'(16/L + 2));
      chk($sformatf("b2b_last_l%0d", L), got[got.size()-1], model_blk(tbl[9].din));
      chk($sformatf("sb_empty_l%0d", L), 128'(sb.size()), 128'd0);
    end

    // stall in HOLD with a new block already waiting
    b1 = tbl[0].din; b2 = tbl[12].din;
    ordy[0] = 1'b0; iv[0] = 1'b1; din[0] = b1; prev_ov = 1'b0;
    t = 0;
    while (!ov[0] && t < 40) begin
      tick(0);
      t++;
      if (n_acc > 0 && irdy[0] == 1'b0) din[0] = b2;
    end
    chk("hold_reached", 128'(ov[0]), 128'd1);
    for (int i = 0; i < 10; i++) begin
      tick(0);
      chk("hold_valid", 128'(ov[0]), 128'd1);
      chk("hold_data", dout[0], tbl[0].exp);
      chk("hold_in_ready", 128'(irdy[0]), 128'd0);
      chk("hold_busy", 128'(bsy[0]), 128'd1);
    end
    ordy[0] = 1'b1;
    tick(0);
    chk("retire_valid", 128'(ov[0]), 128'd0);
    chk("retire_in_ready", 128'(irdy[0]), 128'd1);
    t = 0;
    while (sb.size() != 0 || t == 0) begin
      if (t > 40) break;
      tick(0);
      t++;
      if (sb.size() != 0) iv[0] = 1'b0;
    end
    iv[0] = 1'b0;
    chk("post_hold_block", got[got.size()-1], model_blk(b2));

    // reset while substituting (cnt==2)
    iv[0] = 1'b1; din[0] = tbl[5].din; ordy[0] = 1'b1;
    t = n_acc;
    while (n_acc == t) tick(0);
    iv[0] = 1'b0;
    tick(0);
    tick(0);
    rst = 1'b1;
    tick(0);
    chk("midrst_valid", 128'(ov[0]), 128'd0);
    chk("midrst_data", dout[0], 128'd0);
    chk("midrst_busy", 128'(bsy[0]), 128'd0);
    chk("midrst_ready_in_rst", 128'(irdy[0]), 128'd0);
    rst = 1'b0;
    #1;
    chk("midrst_ready", 128'(irdy[0]), 128'd1);
    sb.delete();
    acc_q.delete();
    prev_ov = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(0);
      chk("midrst_no_stale", 128'(ov[0]), 128'd0);
    end
    stim = {tbl[0].din};
    run_stream(0, 60);
    chk("after_midrst", got[got.size()-1], tbl[0].exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
